pipelined_adder_tree: RTL and testbench

- Parametrised, pipelined successor to the team's combinational adder tree.
- Reduces SIZE operands of DATA_WIDTH bits to one sum. Each tree level is registered, and a valid/ready handshake applies on both sides.
- Optional per-beat accumulate mode sums several consecutive input vectors into one result, with an overflow flag.
- Sits between operand producers (multiplier partial products, MAC lanes) and result consumers.

---
 rtl/adder_pkg.sv | 23 ++
 rtl/adder_tree_stage.sv | 54 +++++
 rtl/pipelined_adder_tree.sv | 128 ++++++++++++
 tb/tb_pipelined_adder_tree.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared types and elaboration helpers for the pipelined adder tree.
//   tag_t       : per-stage side-band {valid, acc, last} travelling with the data
//   tree_levels : number of pairwise reduction levels for a given operand count
//   level_count : number of partial sums held after k reduction levels
package adder_pkg;

   typedef struct packed {
      logic valid;
      logic acc;
      logic last;
   } tag_t;

   // $clog2 with a single operand needing no reduction level
   function automatic int unsigned tree_levels(input int unsigned size);
      return (size <= 32'd1) ? 32'd0 : 32'($clog2(size));
   endfunction

   // ceil(size / 2^k)
   function automatic int unsigned level_count(input int unsigned size, input int unsigned k);
      return (size + (32'd1 << k) - 32'd1) >> k;
   endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered pairwise reduction level of the adder tree.
//   clk, rst_n : clock, async active-low reset
//   en         : load enable (pipeline advance)
//   in_tag     : valid/acc/last of the incoming level, passed through
//   in_data    : IN_COUNT packed elements of IN_WIDTH bits
//   out_tag    : registered tag
//   out_data   : ceil(IN_COUNT/2) packed sums of IN_WIDTH+1 bits
module adder_tree_stage
   import adder_pkg::*;
#(
   parameter int unsigned IN_COUNT = 2,
   parameter int unsigned IN_WIDTH = 4,
   parameter int unsigned SIGNED   = 0,
   localparam int unsigned OUT_COUNT = (IN_COUNT + 1) / 2,
   localparam int unsigned OUT_WIDTH = IN_WIDTH + 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          en,
   input  tag_t                          in_tag,
   input  logic [IN_COUNT*IN_WIDTH-1:0]  in_data,
   output tag_t                          out_tag,
   output logic [OUT_COUNT*OUT_WIDTH-1:0] out_data
);

   logic [OUT_COUNT*OUT_WIDTH-1:0] sum_c;

   // one-bit growth; sign or zero fill depending on operand type
   function automatic logic [OUT_WIDTH-1:0] ext(input logic [IN_WIDTH-1:0] v);
      return (SIGNED != 0) ? {v[IN_WIDTH-1], v} : {1'b0, v};
   endfunction

   // pair 2j/2j+1; an odd trailing element is only extended, never paired
   for (genvar j = 0; j < OUT_COUNT; j++) begin : g_pair
      if (2 * j + 1 < IN_COUNT) begin : g_add
         assign sum_c[j*OUT_WIDTH +: OUT_WIDTH] =
            ext(in_data[(2*j)*IN_WIDTH +: IN_WIDTH]) + ext(in_data[(2*j+1)*IN_WIDTH +: IN_WIDTH]);
      end else begin : g_pass
         assign sum_c[j*OUT_WIDTH +: OUT_WIDTH] = ext(in_data[(2*j)*IN_WIDTH +: IN_WIDTH]);
      end
   end

   // level register; holds while the pipe is stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_tag  <= '0;
         out_data <= '0;
      end else if (en) begin
         out_tag  <= in_tag;
         out_data <= sum_c;
      end
   end

endmodule

// File: rtl/pipelined_adder_tree.sv
// Pipelined SIZE-operand adder tree with valid/ready handshake and packet accumulation.
//   clk, rst_n          : clock, async active-low reset
//   in_valid / in_ready : input handshake (in_ready is combinational)
//   inputs              : SIZE packed operands of DATA_WIDTH bits
//   in_acc, in_last     : beat belongs to an accumulation packet / closes it
//   out_valid/out_ready : output handshake
//   out_sum, out_ovf    : result and accumulation overflow flag
module pipelined_adder_tree
   import adder_pkg::*;
#(
   parameter int unsigned SIZE       = 4,
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned SIGNED     = 0,
   parameter int unsigned ACC_EXTRA  = 8,
   localparam int unsigned LEVELS     = tree_levels(SIZE),
   localparam int unsigned TREE_WIDTH = DATA_WIDTH + LEVELS,
   localparam int unsigned ACC_WIDTH  = TREE_WIDTH + ACC_EXTRA
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [SIZE*DATA_WIDTH-1:0]   inputs,
   input  logic                         in_acc,
   input  logic                         in_last,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [ACC_WIDTH-1:0]         out_sum,
   output logic                         out_ovf
);

   logic                  advance;
   logic [TREE_WIDTH-1:0] tree;
   tag_t                  fin;
   logic [ACC_WIDTH-1:0]  tree_ext;
   logic [ACC_WIDTH-1:0]  acc_reg;
   logic                  acc_ovf;
   logic [ACC_WIDTH:0]    wide;
   logic [ACC_WIDTH-1:0]  sum;
   logic                  add_ovf;

   // whole pipe moves together; a held result freezes every stage
   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // level 0 registers raw operands; level k reduces level k-1
   for (genvar k = 0; k <= LEVELS; k++) begin : g_lvl
      localparam int unsigned CNT = level_count(SIZE, k);
      localparam int unsigned W   = DATA_WIDTH + k;
      logic [CNT*W-1:0] data;
      tag_t             tag;
      if (k == 0) begin : g_in
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               tag  <= '0;
               data <= '0;
            end else if (advance) begin
               tag.valid <= in_valid;
               tag.acc   <= in_acc;
               tag.last  <= in_last;
               data      <= inputs;
            end
         end
      end else begin : g_red
         adder_tree_stage #(
            .IN_COUNT (level_count(SIZE, k - 1)),
            .IN_WIDTH (DATA_WIDTH + k - 1),
            .SIGNED   (SIGNED)
         ) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .en       (advance),
            .in_tag   (g_lvl[k-1].tag),
            .in_data  (g_lvl[k-1].data),
            .out_tag  (tag),
            .out_data (data)
         );
      end
   end

   assign tree = g_lvl[LEVELS].data;
   assign fin  = g_lvl[LEVELS].tag;

   // extend tree result to accumulator width
   always_comb begin
      tree_ext = ACC_WIDTH'(tree);
      if (SIGNED != 0) begin
         tree_ext = ACC_WIDTH'($signed(tree));
      end
   end

   // accumulator add with carry-out / signed overflow detection
   assign wide    = {1'b0, acc_reg} + {1'b0, tree_ext};
   assign sum     = wide[ACC_WIDTH-1:0];
   assign add_ovf = (SIGNED != 0)
                  ? ((acc_reg[ACC_WIDTH-1] == tree_ext[ACC_WIDTH-1]) && (sum[ACC_WIDTH-1] != acc_reg[ACC_WIDTH-1]))
                  : wide[ACC_WIDTH];

   // output / accumulator stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_sum   <= '0;
         out_ovf   <= 1'b0;
         acc_reg   <= '0;
         acc_ovf   <= 1'b0;
      end else if (advance) begin
         out_valid <= 1'b0;
         if (fin.valid) begin
            if (!fin.acc) begin
               out_valid <= 1'b1;
               out_sum   <= tree_ext;
               out_ovf   <= 1'b0;
            end else if (!fin.last) begin
               acc_reg <= sum;
               acc_ovf <= acc_ovf | add_ovf;
            end else begin
               out_valid <= 1'b1;
               out_sum   <= sum;
               out_ovf   <= acc_ovf | add_ovf;
               acc_reg   <= '0;
               acc_ovf   <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder_tree.sv
// Directed and randomized-handshake bench for pipelined_adder_tree in three configurations.
module tb_pipelined_adder_tree;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   // A: SIZE=4 DW=4 unsigned ACC_EXTRA=8 -> ACC_WIDTH=14
   logic        a_in_valid, a_in_ready, a_in_acc, a_in_last, a_out_valid, a_out_ready, a_out_ovf;
   logic [15:0] a_inputs;
   logic [13:0] a_out_sum;
   // B: SIZE=5 DW=4 signed ACC_EXTRA=8 -> ACC_WIDTH=15
   logic        b_in_valid, b_in_ready, b_in_acc, b_in_last, b_out_valid, b_out_ready, b_out_ovf;
   logic [19:0] b_inputs;
   logic [14:0] b_out_sum;
   // C: SIZE=2 DW=4 unsigned ACC_EXTRA=0 -> ACC_WIDTH=5
   logic        c_in_valid, c_in_ready, c_in_acc, c_in_last, c_out_valid, c_out_ready, c_out_ovf;
   logic [7:0]  c_inputs;
   logic [4:0]  c_out_sum;

   pipelined_adder_tree #(.SIZE(4), .DATA_WIDTH(4), .SIGNED(0), .ACC_EXTRA(8)) u_dut_a (
      .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready), .inputs(a_inputs),
      .in_acc(a_in_acc), .in_last(a_in_last), .out_valid(a_out_valid), .out_ready(a_out_ready),
      .out_sum(a_out_sum), .out_ovf(a_out_ovf));

   pipelined_adder_tree #(.SIZE(5), .DATA_WIDTH(4), .SIGNED(1), .ACC_EXTRA(8)) u_dut_b (
      .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready), .inputs(b_inputs),
      .in_acc(b_in_acc), .in_last(b_in_last), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .out_sum(b_out_sum), .out_ovf(b_out_ovf));

   pipelined_adder_tree #(.SIZE(2), .DATA_WIDTH(4), .SIGNED(0), .ACC_EXTRA(0)) u_dut_c (
      .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready), .inputs(c_inputs),
      .in_acc(c_in_acc), .in_last(c_in_last), .out_valid(c_out_valid), .out_ready(c_out_ready),
      .out_sum(c_out_sum), .out_ovf(c_out_ovf));

   int checks = 0;
   int errors = 0;

   typedef struct packed { logic [13:0] sum; logic ovf; } res_t;
   typedef struct packed { logic [15:0] d; logic acc; logic last; logic out; logic [13:0] sum; logic ovf; } vec_t;
   typedef struct packed { logic [19:0] d; logic [14:0] sum; } bvec_t;
   typedef struct packed { logic [7:0] d; logic acc; logic last; } cbeat_t;
   typedef struct packed { logic [4:0] sum; logic ovf; } cres_t;

   res_t        exp_q[$];
   logic        stalled_prev;
   logic [13:0] prev_sum;
   logic        prev_ovf;
   logic [13:0] m_acc;
   logic        m_ovf;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one cycle on DUT A: drive, check handshake/stability/output, then clock
   task automatic cyc(input logic v, input logic [15:0] d, input logic a, input logic l,
                      input logic r, output logic accepted);
      res_t e;
      a_in_valid = v; a_inputs = d; a_in_acc = a; a_in_last = l; a_out_ready = r;
      #1;
      chk("in_ready_rule", 32'(a_in_ready), 32'(!(a_out_valid && !a_out_ready)));
      if (stalled_prev) begin
         chk("stall_valid", 32'(a_out_valid), 32'd1);
         chk("stall_sum", 32'(a_out_sum), 32'(prev_sum));
         chk("stall_ovf", 32'(a_out_ovf), 32'(prev_ovf));
      end
      if (a_out_valid && a_out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%0d required=none", a_out_sum);
         end else begin
            e = exp_q.pop_front();
            chk("out_sum", 32'(a_out_sum), 32'(e.sum));
            chk("out_ovf", 32'(a_out_ovf), 32'(e.ovf));
         end
      end
      accepted     = v && a_in_ready;
      stalled_prev = a_out_valid && !a_out_ready;
      prev_sum     = a_out_sum;
      prev_ovf     = a_out_ovf;
      tick();
   endtask

   // transaction-level reference for DUT A
   task automatic model(input logic [15:0] d, input logic a, input logic l);
      logic [14:0] w;
      logic [13:0] t;
      t = 14'(d[3:0]) + 14'(d[7:4]) + 14'(d[11:8]) + 14'(d[15:12]);
      if (!a) begin
         exp_q.push_back('{sum: t, ovf: 1'b0});
      end else begin
         w = {1'b0, m_acc} + {1'b0, t};
         if (l) begin
            exp_q.push_back('{sum: w[13:0], ovf: m_ovf | w[14]});
            m_acc = '0;
            m_ovf = 1'b0;
         end else begin
            m_acc = w[13:0];
            m_ovf = m_ovf | w[14];
         end
      end
   endtask

   initial begin
      vec_t   tbl[11];
      bvec_t  btbl[3];
      cbeat_t cb[4];
      cres_t  cexp[3];
      logic   ok, v, a, l, r;
      logic [15:0] d;
      int acc_n, cyc_n, k;

      tbl[0]  = '{16'h4321, 1'b0, 1'b0, 1'b1, 14'd10, 1'b0};
      tbl[1]  = '{16'hFFFF, 1'b0, 1'b0, 1'b1, 14'd60, 1'b0};
      tbl[2]  = '{16'h0000, 1'b0, 1'b0, 1'b1, 14'd0,  1'b0};
      tbl[3]  = '{16'h1111, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0};
      tbl[4]  = '{16'h0005, 1'b0, 1'b0, 1'b1, 14'd5,  1'b0};
      tbl[5]  = '{16'h2222, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0};
      tbl[6]  = '{16'h9999, 1'b0, 1'b0, 1'b1, 14'd36, 1'b0};
      tbl[7]  = '{16'h3333, 1'b1, 1'b1, 1'b1, 14'd24, 1'b0};
      tbl[8]  = '{16'hFFFF, 1'b1, 1'b0, 1'b0, 14'd0,  1'b0};
      tbl[9]  = '{16'h1007, 1'b0, 1'b1, 1'b1, 14'd8,  1'b0};
      tbl[10] = '{16'h0000, 1'b1, 1'b1, 1'b1, 14'd60, 1'b0};

      btbl[0] = '{20'h30F78, 15'd1};       // {-8,7,-1,0,3}
      btbl[1] = '{20'h88888, 15'h7FD8};    // 5 x -8 = -40
      btbl[2] = '{20'hD0000, 15'h7FFD};    // only trailing odd element, -3

      cb[0] = '{8'hFF, 1'b1, 1'b0};
      cb[1] = '{8'hFF, 1'b1, 1'b1};
      cb[2] = '{8'h11, 1'b1, 1'b1};
      cb[3] = '{8'hFF, 1'b0, 1'b0};
      cexp[0] = '{5'd28, 1'b1};
      cexp[1] = '{5'd2,  1'b0};
      cexp[2] = '{5'd30, 1'b0};

      rst_n = 1'b0;
      a_in_valid = 0; a_inputs = '0; a_in_acc = 0; a_in_last = 0; a_out_ready = 1;
      b_in_valid = 0; b_inputs = '0; b_in_acc = 0; b_in_last = 0; b_out_ready = 1;
      c_in_valid = 0; c_inputs = '0; c_in_acc = 0; c_in_last = 0; c_out_ready = 1;
      stalled_prev = 0; prev_sum = '0; prev_ovf = 0; m_acc = '0; m_ovf = 0;

      // reset state
      #3;
      chk("rst_a_valid", 32'(a_out_valid), 32'd0);
      chk("rst_a_sum", 32'(a_out_sum), 32'd0);
      chk("rst_a_ovf", 32'(a_out_ovf), 32'd0);
      chk("rst_b_valid", 32'(b_out_valid), 32'd0);
      chk("rst_c_valid", 32'(c_out_valid), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      #1;
      chk("rst_a_ready", 32'(a_in_ready), 32'd1);
      chk("rst_c_ready", 32'(c_in_ready), 32'd1);

      // latency: {1,2,3,4} -> 10 three edges after acceptance
      cyc(1'b1, 16'h4321, 1'b0, 1'b0, 1'b1, ok);
      chk("lat_accept", 32'(ok), 32'd1);
      exp_q.push_back('{sum: 14'd10, ovf: 1'b0});
      chk("lat_valid_e0", 32'(a_out_valid), 32'd0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("lat_valid_e1", 32'(a_out_valid), 32'd0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("lat_valid_e2", 32'(a_out_valid), 32'd0);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("lat_valid_e3", 32'(a_out_valid), 32'd1);
      chk("lat_sum_e3", 32'(a_out_sum), 32'd10);
      repeat (2) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("lat_drain", 32'(exp_q.size()), 32'd0);

      // table: standalone beats interleaved with an accumulation packet
      for (int i = 0; i < 11; i++) begin
         cyc(1'b1, tbl[i].d, tbl[i].acc, tbl[i].last, 1'b1, ok);
         chk("tbl_accept", 32'(ok), 32'd1);
         if (tbl[i].out) exp_q.push_back('{sum: tbl[i].sum, ovf: tbl[i].ovf});
      end
      repeat (6) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("tbl_drain", 32'(exp_q.size()), 32'd0);

      // random handshake against the reference model
      acc_n = 0;
      cyc_n = 0;
      while ((acc_n < 1000 || exp_q.size() != 0) && cyc_n < 8000) begin
         v = (acc_n < 1000) && ($urandom_range(0, 3) != 0);
         d = 16'($urandom);
         a = 1'($urandom_range(0, 1));
         l = ($urandom_range(0, 2) == 0);
         r = ($urandom_range(0, 3) != 0);
         cyc(v, d, a, l, r, ok);
         if (ok) begin
            model(d, a, l);
            acc_n++;
         end
         cyc_n++;
      end
      chk("rand_beats", 32'(acc_n), 32'd1000);
      chk("rand_drain", 32'(exp_q.size()), 32'd0);
      // close any open random packet so the accumulator is empty
      cyc(1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, ok);
      if (ok) model(16'h0000, 1'b1, 1'b1);
      repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("rand_close", 32'(exp_q.size()), 32'd0);

      // signed SIZE=5: four-edge latency, odd passthrough
      for (int i = 0; i < 3; i++) begin
         b_in_valid = 1'b1; b_inputs = btbl[i].d; b_in_acc = 1'b0;
         #1;
         chk("b_ready", 32'(b_in_ready), 32'd1);
         tick();
         b_in_valid = 1'b0;
         for (int c = 1; c <= 4; c++) begin
            tick();
            if (c < 4) begin
               chk("b_early_valid", 32'(b_out_valid), 32'd0);
            end else begin
               chk("b_valid", 32'(b_out_valid), 32'd1);
               chk("b_sum", 32'(b_out_sum), 32'(btbl[i].sum));
               chk("b_ovf", 32'(b_out_ovf), 32'd0);
            end
         end
         tick();
      end

      // narrow accumulator: overflow, sticky clear, standalone
      k = 0;
      for (int i = 0; i < 8; i++) begin
         if (i < 4) begin
            c_in_valid = 1'b1; c_inputs = cb[i].d; c_in_acc = cb[i].acc; c_in_last = cb[i].last;
         end else begin
            c_in_valid = 1'b0;
         end
         tick();
         if (c_out_valid) begin
            if (k < 3) begin
               chk("c_sum", 32'(c_out_sum), 32'(cexp[k].sum));
               chk("c_ovf", 32'(c_out_ovf), 32'(cexp[k].ovf));
            end
            k++;
         end
      end
      chk("c_count", 32'(k), 32'd3);

      // reset with a held result and two accumulation beats in flight
      stalled_prev = 0;
      cyc(1'b1, 16'h4321, 1'b0, 1'b0, 1'b1, ok);
      cyc(1'b1, 16'h1111, 1'b1, 1'b0, 1'b1, ok);
      cyc(1'b1, 16'h2222, 1'b1, 1'b0, 1'b0, ok);
      chk("mr_accept", 32'(ok), 32'd1);
      cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b0, ok);
      chk("mr_pre_valid", 32'(a_out_valid), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mr_valid", 32'(a_out_valid), 32'd0);
      chk("mr_sum", 32'(a_out_sum), 32'd0);
      chk("mr_ready", 32'(a_in_ready), 32'd1);
      exp_q.delete();
      stalled_prev = 0;
      a_in_valid = 1'b0;
      a_out_ready = 1'b1;
      tick(); tick();
      rst_n = 1'b1;
      #1;
      cyc(1'b1, 16'h4321, 1'b1, 1'b1, 1'b1, ok);
      chk("mr_post_accept", 32'(ok), 32'd1);
      exp_q.push_back('{sum: 14'd10, ovf: 1'b0});
      repeat (5) cyc(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, ok);
      chk("mr_drain", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
